// File: rtl/store_unit.sv
// store_unit: RISC-V store path. It computes the effective address, checks alignment and funct3, then drives a byte-enabled word write and holds it until mem_ack.
// Ports: clk/rst (sync, active-high); st_valid/st_ready/st_base/st_offset/st_data/st_funct3 (request);
//        mem_we/mem_addr/mem_wdata/mem_be/mem_ack (memory write port);
//        done/err/err_cause (completion pulses); busy, store_cnt (status).
module store_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_base,
    input  logic [11:0]      st_offset,
    input  logic [31:0]      st_data,
    input  logic [2:0]       st_funct3,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_cause,
    output logic             busy,
    output logic [CNT_W-1:0] store_cnt
);
    typedef enum logic [1:0] {IDLE, WRITE, RESP, ERR} state_t;
    state_t           state_q;
    logic [7:0]       wait_q;
    logic [31:0]      addr_q, wdata_q;
    logic [3:0]       be_q;
    logic [1:0]       cause_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      ea, wdata_d;
    logic [3:0]       be_d;
    logic             illegal, misaligned;
    assign ea         = st_base + {{20{st_offset[11]}}, st_offset};
    assign illegal    = st_funct3 > 3'b010;
    assign misaligned = (st_funct3 == 3'b001 && ea[0]) || (st_funct3 == 3'b010 && ea[1:0] != 2'b00);
    assign be_d       = st_funct3 == 3'b000 ? 4'b0001 << ea[1:0] :
                        st_funct3 == 3'b001 ? 4'b0011 << ea[1:0] : 4'b1111;
    assign wdata_d    = st_funct3 == 3'b000 ? {4{st_data[7:0]}} :
                        st_funct3 == 3'b001 ? {2{st_data[15:0]}} : st_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (st_valid) begin
                    wait_q <= '0;
                    if (illegal || misaligned) begin
                        cause_q <= illegal ? 2'b10 : 2'b01;
                        state_q <= ERR;
                    end else begin
                        addr_q  <= {ea[31:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        state_q <= WRITE;
                    end
                end
                // Ack is tested first so an ack in the final allowed cycle still completes.
                WRITE: if (mem_ack) begin
                    state_q <= RESP;
                end else if (wait_q == 8'(TIMEOUT - 1)) begin
                    cause_q <= 2'b11;
                    state_q <= ERR;
                end else begin
                    wait_q <= wait_q + 8'd1;
                end
                RESP: begin
                    cnt_q   <= &cnt_q ? cnt_q : cnt_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign st_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign mem_we    = state_q == WRITE;
    assign done      = state_q == RESP;
    assign err       = state_q == ERR;
    assign err_cause = err ? cause_q : 2'b00;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign store_cnt = cnt_q;
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: scoreboard bench for store_unit (TIMEOUT=4, CNT_W=2 so saturation is reachable).
module tb_store_unit;
    typedef struct packed {
        logic        err;
        logic [1:0]  cause;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;
    logic        clk = 0, rst = 1, st_valid = 0, mem_ack = 0;
    logic [31:0] st_base = 0, st_data = 0;
    logic [11:0] st_offset = 0;
    logic [2:0]  st_funct3 = 0;
    logic        st_ready, mem_we, done, err, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [1:0]  err_cause, store_cnt;
    exp_t        exp_q[$];
    int          checks = 0, failures = 0;
    store_unit #(.TIMEOUT(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
        .st_base(st_base), .st_offset(st_offset), .st_data(st_data), .st_funct3(st_funct3),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .done(done), .err(err), .err_cause(err_cause),
        .busy(busy), .store_cnt(store_cnt)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal;
    end
    task automatic issue(input logic [31:0] b, input logic [11:0] o, input logic [31:0] d, input logic [2:0] f);
        st_valid = 1; st_base = b; st_offset = o; st_data = d; st_funct3 = f;
        @(posedge clk); #1;
        st_valid = 0; st_base = 32'hFFFF_FFFF; st_offset = 12'h7FF; st_data = 32'h0BAD_0BAD; st_funct3 = 3'b111;
    endtask
    task automatic run_txn(input int ack_at, output int we_n, output exp_t obs, output logic dn);
        we_n = 0; obs = '0; dn = 0;
        for (int c = 0; c < 40 && !dn && !obs.err; c++) begin
            @(negedge clk);
            mem_ack = 0;
            if (mem_we) begin
                we_n++;
                if (we_n == 1) begin obs.addr = mem_addr; obs.wdata = mem_wdata; obs.be = mem_be; end
                if (we_n == ack_at) mem_ack = 1;
            end
            dn = done; obs.err = err; obs.cause = err_cause;
        end
    endtask
    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++;
        if ({st_ready, mem_we, mem_addr, mem_wdata, mem_be, done, err, err_cause, busy, store_cnt} !== {1'b1, 76'b0}) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", {st_ready, mem_we, mem_addr, mem_wdata, mem_be, done, err, err_cause, busy, store_cnt}, {1'b1, 76'b0});
        end
        @(posedge clk); #1;
    endtask
    task automatic test_store(input string nm, input logic [31:0] b, input logic [11:0] o, input logic [31:0] d,
                              input logic [2:0] f, input int ack_at, input int exp_we, input exp_t e, input logic [1:0] exp_cnt);
        int we_n; exp_t obs, got; logic dn;
        exp_q.push_back(e);
        issue(b, o, d, f);
        run_txn(ack_at, we_n, obs, dn);
        got = exp_q.pop_front();
        checks++;
        if (obs !== got) begin failures++; $display("FAIL %s_txn got=%h exp=%h", nm, obs, got); end
        checks++;
        if (we_n != exp_we) begin failures++; $display("FAIL %s_we_cycles got=%0d exp=%0d", nm, we_n, exp_we); end
        checks++;
        if (dn !== !got.err) begin failures++; $display("FAIL %s_done got=%b exp=%b", nm, dn, !got.err); end
        @(posedge clk); #1;
        checks++;
        if ({done, err, st_ready, busy, store_cnt} !== {4'b0010, exp_cnt}) begin
            failures++;
            $display("FAIL %s_after got=%b exp=%b", nm, {done, err, st_ready, busy, store_cnt}, {4'b0010, exp_cnt});
        end
    endtask
    task automatic test_errors;
        test_store("sh_mis", 32'h29, 12'h000, 32'h1111, 3'b001, 1, 0, '{err:1, cause:2'b01, default:'0}, 2'd3);
        test_store("f3_011", 32'h00, 12'h000, 32'h2222, 3'b011, 1, 0, '{err:1, cause:2'b10, default:'0}, 2'd3);
        test_store("sw_mis", 32'h2A, 12'h000, 32'h3333, 3'b010, 1, 0, '{err:1, cause:2'b01, default:'0}, 2'd3);
        test_store("f3_111", 32'h01, 12'h000, 32'h4444, 3'b111, 1, 0, '{err:1, cause:2'b10, default:'0}, 2'd3);
    endtask
    task automatic test_timeout;
        test_store("timeout", 32'h100, 12'h000, 32'hA5A5A5A5, 3'b010, 0, 4,
                   '{err:1, cause:2'b11, addr:32'h100, wdata:32'hA5A5A5A5, be:4'hF}, 2'd3);
        test_store("ack_last", 32'h104, 12'hFFC, 32'h11223344, 3'b010, 4, 4,
                   '{err:0, cause:2'b00, addr:32'h100, wdata:32'h11223344, be:4'hF}, 2'd3);
    endtask
    task automatic test_reset_write;
        issue(32'h40, 12'h000, 32'h55AA55AA, 3'b010);
        @(negedge clk);
        checks++;
        if (mem_we !== 1) begin failures++; $display("FAIL rst_write_we got=%b exp=1", mem_we); end
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        checks++;
        if ({st_ready, mem_we, mem_addr, mem_wdata, mem_be, done, err, err_cause, busy, store_cnt} !== {1'b1, 76'b0}) begin
            failures++;
            $display("FAIL rst_write_values got=%h exp=%h", {st_ready, mem_we, mem_addr, mem_wdata, mem_be, done, err, err_cause, busy, store_cnt}, {1'b1, 76'b0});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({done, err} !== 2'b00) begin failures++; $display("FAIL rst_write_pulse got=%b exp=00", {done, err}); end
        end
        @(posedge clk); #1;
    endtask
    task automatic test_stray_ack;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ack = 1;
            @(negedge clk);
            checks++;
            if ({done, busy, mem_we} !== 3'b000) begin failures++; $display("FAIL stray_ack got=%b exp=000", {done, busy, mem_we}); end
        end
        mem_ack = 0;
        @(posedge clk); #1;
    endtask
    task automatic test_back_to_back;
        test_store("b2b_sb1", 32'h0, 12'h001, 32'h000000AB, 3'b000, 1, 1,
                   '{err:0, cause:2'b00, addr:32'h0, wdata:32'hABABABAB, be:4'h2}, 2'd1);
        test_store("b2b_sb2", 32'h0, 12'h7FF, 32'h0000005A, 3'b000, 1, 1,
                   '{err:0, cause:2'b00, addr:32'h7FC, wdata:32'h5A5A5A5A, be:4'h8}, 2'd2);
        test_store("b2b_sh", 32'hFFFFFFFE, 12'h000, 32'h00001234, 3'b001, 1, 1,
                   '{err:0, cause:2'b00, addr:32'hFFFFFFFC, wdata:32'h12341234, be:4'hC}, 2'd3);
        test_store("b2b_sw", 32'hFFFFFFFC, 12'h008, 32'hCAFEF00D, 3'b010, 1, 1,
                   '{err:0, cause:2'b00, addr:32'h4, wdata:32'hCAFEF00D, be:4'hF}, 2'd3);
    endtask
    initial begin
        test_reset;
        test_store("sw", 32'h28, 12'h000, 32'h12345678, 3'b010, 2, 2,
                   '{err:0, cause:2'b00, addr:32'h28, wdata:32'h12345678, be:4'hF}, 2'd1);
        test_store("sb", 32'h29, 12'h002, 32'hDEADBEEF, 3'b000, 1, 1,
                   '{err:0, cause:2'b00, addr:32'h28, wdata:32'hEFEFEFEF, be:4'h8}, 2'd2);
        test_store("sh", 32'h30, 12'hFFE, 32'h0000CAFE, 3'b001, 3, 3,
                   '{err:0, cause:2'b00, addr:32'h2C, wdata:32'hCAFECAFE, be:4'hC}, 2'd3);
        test_errors;
        test_timeout;
        test_reset_write;
        test_stray_ack;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
